// File: rtl/argmax_unit_pkg.sv
// argmax_unit_pkg: shared defaults, state encoding and index-width helper for the argmax classifier
`ifndef NN_FINAL_LAYER_NEURONS
`define NN_FINAL_LAYER_NEURONS 10
`endif
`ifndef NN_DATA_WIDTH
`define NN_DATA_WIDTH 16
`endif

package argmax_unit_pkg;

    localparam int DEF_NUM_INPUTS = `NN_FINAL_LAYER_NEURONS;
    localparam int DEF_DATA_WIDTH = `NN_DATA_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Bits needed to index n elements, never less than one.
    function automatic int idx_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: strict greater-than compare of a candidate against the running max
module argmax_cmp
    import argmax_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SIGNED_CMP = 0
) (
    input  logic [DATA_WIDTH-1:0] cand,
    input  logic [DATA_WIDTH-1:0] cur_max,
    output logic                  gt
);

    assign gt = (SIGNED_CMP != 0) ? ($signed(cand) > $signed(cur_max)) : (cand > cur_max);

endmodule

// File: rtl/argmax_unit.sv
// argmax_unit: sequential argmax over the final layer's output vector, one element per clock
module argmax_unit
    import argmax_unit_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = 32,
    parameter int SIGNED_CMP = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
    output logic                             o_busy,
    output logic                             o_valid,
    output logic [OUT_WIDTH-1:0]             o_index,
    output logic [DATA_WIDTH-1:0]            o_max,
    output logic                             o_overrun
);

    localparam int IDX_W = idx_width(NUM_INPUTS);
    localparam int VEC_W = NUM_INPUTS * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INPUTS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    start;
    logic                    finish;
    logic                    gt;
    logic [VEC_W-1:0]        shreg;
    logic [DATA_WIDTH-1:0]   cand;
    logic [DATA_WIDTH-1:0]   run_max;
    logic [DATA_WIDTH-1:0]   new_max;
    logic [IDX_W-1:0]        run_idx;
    logic [IDX_W-1:0]        new_idx;
    logic [IDX_W-1:0]        cnt;

    // The element under test always sits in the low lane of the shift register.
    assign cand    = shreg[DATA_WIDTH-1:0];
    assign new_max = gt ? cand : run_max;
    assign new_idx = gt ? cnt : run_idx;
    assign o_busy  = (state == SCAN);

    argmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
        .cand    (cand),
        .cur_max (run_max),
        .gt      (gt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: accept a vector when idle, finish after the last element is compared.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        if (state == IDLE) begin
            start = i_valid;
            if (i_valid && NUM_INPUTS > 1)
                state_nxt = SCAN;
        end else begin
            finish = (cnt == LAST);
            if (finish)
                state_nxt = IDLE;
        end
    end

    // Datapath: running max/index are kept apart from the published result so outputs hold during a scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            cnt       <= '0;
            o_valid   <= 1'b0;
            o_index   <= '0;
            o_max     <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (start) begin
                shreg   <= i_data >> DATA_WIDTH;
                run_max <= i_data[DATA_WIDTH-1:0];
                run_idx <= '0;
                cnt     <= IDX_W'(1);
                if (NUM_INPUTS == 1) begin
                    o_valid <= 1'b1;
                    o_max   <= i_data[DATA_WIDTH-1:0];
                    o_index <= '0;
                end
            end else if (state == SCAN) begin
                shreg   <= shreg >> DATA_WIDTH;
                run_max <= new_max;
                run_idx <= new_idx;
                cnt     <= cnt + 1'b1;
                if (finish) begin
                    o_valid <= 1'b1;
                    o_max   <= new_max;
                    o_index <= OUT_WIDTH'(new_idx);
                end
            end
            if (state == SCAN && i_valid)
                o_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_argmax_unit.sv
// tb_argmax_unit: directed, table-driven checks of argmax_unit in unsigned, signed and single-input builds
module tb_argmax_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         va = 1'b0, vs = 1'b0, v1 = 1'b0;
    logic [159:0] da = '0, ds = '0;
    logic [15:0]  d1 = '0;

    logic        ua_busy, ua_valid, ua_ovr;
    logic [31:0] ua_idx;
    logic [15:0] ua_max;
    logic        sg_busy, sg_valid, sg_ovr;
    logic [31:0] sg_idx;
    logic [15:0] sg_max;
    logic        s1_busy, s1_valid, s1_ovr;
    logic [31:0] s1_idx;
    logic [15:0] s1_max;

    argmax_unit #(.NUM_INPUTS(10), .DATA_WIDTH(16), .OUT_WIDTH(32), .SIGNED_CMP(0)) u_uns (
        .clk(clk), .rst(rst), .i_valid(va), .i_data(da),
        .o_busy(ua_busy), .o_valid(ua_valid), .o_index(ua_idx), .o_max(ua_max), .o_overrun(ua_ovr)
    );

    argmax_unit #(.NUM_INPUTS(10), .DATA_WIDTH(16), .OUT_WIDTH(32), .SIGNED_CMP(1)) u_sgn (
        .clk(clk), .rst(rst), .i_valid(vs), .i_data(ds),
        .o_busy(sg_busy), .o_valid(sg_valid), .o_index(sg_idx), .o_max(sg_max), .o_overrun(sg_ovr)
    );

    argmax_unit #(.NUM_INPUTS(1), .DATA_WIDTH(16), .OUT_WIDTH(32), .SIGNED_CMP(0)) u_one (
        .clk(clk), .rst(rst), .i_valid(v1), .i_data(d1),
        .o_busy(s1_busy), .o_valid(s1_valid), .o_index(s1_idx), .o_max(s1_max), .o_overrun(s1_ovr)
    );

    int checks = 0;
    int errors = 0;
    logic s1_busy_seen = 1'b0;

    always @(negedge clk) if (s1_busy) s1_busy_seen <= 1'b1;

    typedef struct {
        logic         sgn;
        logic [159:0] data;
        logic [31:0]  idx;
        logic [15:0]  mx;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [159:0] pk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        return {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int k);
        int   n;
        logic busy_ok;
        logic cv;
        if (tbl[k].sgn) begin ds = tbl[k].data; vs = 1'b1; end
        else begin da = tbl[k].data; va = 1'b1; end
        tick();
        va = 1'b0;
        vs = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        cv = tbl[k].sgn ? sg_valid : ua_valid;
        while (n < 30 && !cv) begin
            if (!(tbl[k].sgn ? sg_busy : ua_busy)) busy_ok = 1'b0;
            tick();
            n++;
            cv = tbl[k].sgn ? sg_valid : ua_valid;
        end
        chk($sformatf("vec%0d_latency", k), n, 10);
        chk($sformatf("vec%0d_busy_during_scan", k), {31'd0, busy_ok}, 1);
        chk($sformatf("vec%0d_index", k), tbl[k].sgn ? sg_idx : ua_idx, tbl[k].idx);
        chk($sformatf("vec%0d_max", k), {16'd0, tbl[k].sgn ? sg_max : ua_max}, {16'd0, tbl[k].mx});
        chk($sformatf("vec%0d_busy_at_done", k), {31'd0, tbl[k].sgn ? sg_busy : ua_busy}, 0);
        tick();
        chk($sformatf("vec%0d_valid_one_cycle", k), {31'd0, tbl[k].sgn ? sg_valid : ua_valid}, 0);
    endtask

    logic [159:0] v_a, v_b;

    initial begin
        v_a = pk(16'd3, 16'd9, 16'd1, 16'd0, 16'd4, 16'd2, 16'd8, 16'h7FFF, 16'd5, 16'd6);
        v_b = pk(16'd1, 16'd2, 16'h0100, 16'd5, 16'd5, 16'h0100, 16'd0, 16'd0, 16'd0, 16'd0);
        tbl[0] = '{1'b0, '0, 32'd0, 16'h0000};
        tbl[1] = '{1'b0, v_a, 32'd7, 16'h7FFF};
        tbl[2] = '{1'b1, pk(16'h8001, 16'h8003, 16'h8000, 16'h8005, 16'h8002, 16'h8004, 16'h8000, 16'h8001, 16'h8003, 16'hFFFF), 32'd9, 16'hFFFF};
        tbl[3] = '{1'b0, pk(16'hFFFF, 16'h8003, 16'h8000, 16'h8005, 16'h8002, 16'h8004, 16'h8000, 16'h8001, 16'h8003, 16'hFFFF), 32'd0, 16'hFFFF};
        tbl[4] = '{1'b1, pk(16'h0002, 16'h8005, 16'h8001, 16'h8003, 16'h8000, 16'h8004, 16'h8002, 16'h8005, 16'h8001, 16'hFFFF), 32'd0, 16'h0002};
        tbl[5] = '{1'b0, pk(16'h0002, 16'h8005, 16'h8001, 16'h8003, 16'h8000, 16'h8004, 16'h8002, 16'h8005, 16'h8001, 16'hFFFF), 32'd9, 16'hFFFF};
        tbl[6] = '{1'b1, pk(16'h8000, 16'hFFFE, 16'h8003, 16'hFFFE, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000), 32'd1, 16'hFFFE};
        tbl[7] = '{1'b0, v_b, 32'd2, 16'h0100};

        #2 rst = 1'b1;
        #2;
        chk("rst_busy", {31'd0, ua_busy}, 0);
        chk("rst_valid", {31'd0, ua_valid}, 0);
        chk("rst_index", ua_idx, 0);
        chk("rst_max", {16'd0, ua_max}, 0);
        chk("rst_overrun", {31'd0, ua_ovr}, 0);
        chk("rst_one_valid", {31'd0, s1_valid}, 0);
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) run_vec(k);

        // Dropped strobe mid-scan, then a strobe coincident with o_valid.
        chk("ovr_clear_before", {31'd0, ua_ovr}, 0);
        for (int c = 0; c <= 20; c++) begin
            va = (c == 0 || c == 4 || c == 10);
            da = (c == 4 || c == 10) ? v_b : v_a;
            chk($sformatf("b2b_valid_c%0d", c), {31'd0, ua_valid}, {31'd0, (c == 10 || c == 20)});
            if (c == 4) chk("ovr_c4", {31'd0, ua_ovr}, 0);
            if (c == 5) begin
                chk("ovr_c5", {31'd0, ua_ovr}, 1);
                chk("hold_index_c5", ua_idx, 2);
                chk("hold_max_c5", {16'd0, ua_max}, 32'h0100);
            end
            if (c == 10) begin
                chk("b2b_first_index", ua_idx, 7);
                chk("b2b_first_max", {16'd0, ua_max}, 32'h7FFF);
            end
            if (c == 20) begin
                chk("b2b_second_index", ua_idx, 2);
                chk("b2b_second_max", {16'd0, ua_max}, 32'h0100);
                chk("ovr_sticky", {31'd0, ua_ovr}, 1);
            end
            tick();
        end
        va = 1'b0;
        tick();

        // Asynchronous reset in the middle of a scan.
        for (int c = 0; c <= 18; c++) begin
            va = (c == 0 || c == 8);
            da = (c == 0) ? v_b : v_a;
            if (c == 5) begin
                #2 rst = 1'b1;
                #1;
                chk("midrst_busy", {31'd0, ua_busy}, 0);
                chk("midrst_index", ua_idx, 0);
                chk("midrst_max", {16'd0, ua_max}, 0);
                chk("midrst_overrun", {31'd0, ua_ovr}, 0);
                #1 rst = 1'b0;
            end
            chk($sformatf("midrst_valid_c%0d", c), {31'd0, ua_valid}, {31'd0, (c == 18)});
            if (c == 18) begin
                chk("midrst_index_after", ua_idx, 7);
                chk("midrst_max_after", {16'd0, ua_max}, 32'h7FFF);
            end
            tick();
        end
        va = 1'b0;

        // Single-element build: result the cycle after the strobe, never busy.
        d1 = 16'h1234;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        chk("one_valid", {31'd0, s1_valid}, 1);
        chk("one_index", s1_idx, 0);
        chk("one_max", {16'd0, s1_max}, 32'h1234);
        d1 = 16'hBEEF;
        tick();
        chk("one_valid_pulse", {31'd0, s1_valid}, 0);
        chk("one_max_hold", {16'd0, s1_max}, 32'h1234);
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        chk("one_valid2", {31'd0, s1_valid}, 1);
        chk("one_max2", {16'd0, s1_max}, 32'hBEEF);
        tick();
        chk("one_never_busy", {31'd0, s1_busy_seen}, 0);
        chk("one_no_overrun", {31'd0, s1_ovr}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
